prince_sbox_layer_ctrl: RTL and testbench

- Sequences one full 64-bit, 3-share PRINCE inverse S-box layer through a bank of NUM_SBOX external masked inverse S-box instances (second-order, fixed pipeline latency LATENCY).
- Slices the 16 shared nibbles into batches and issues one batch per cycle while fresh randomness is available.
- Distributes fresh randomness to every instance, tracks in-flight batches with a valid/index pipe, and reassembles the three output shares.
- Sits between the round controller and the S-box bank.

---
 rtl/prince_sbox_layer_ctrl.sv | 102 ++++++++++
 tb/tb_prince_sbox_layer_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_sbox_layer_ctrl.sv
// prince_sbox_layer_ctrl: issues one 3-share PRINCE inverse S-box layer through an external
// bank of masked S-box instances and reassembles the result shares.
module prince_sbox_layer_ctrl #(
    parameter int NUM_SBOX = 4,
    parameter int LATENCY  = 4,
    parameter int RAND_W   = 42
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [63:0]                st1,
    input  logic [63:0]                st2,
    input  logic [63:0]                st3,
    output logic                       busy,
    output logic                       done,
    output logic [63:0]                res1,
    output logic [63:0]                res2,
    output logic [63:0]                res3,
    input  logic [NUM_SBOX*RAND_W-1:0] rand_in,
    input  logic                       rand_valid,
    output logic                       rand_ready,
    output logic                       rand_starve,
    output logic [NUM_SBOX*4-1:0]      sb_in1,
    output logic [NUM_SBOX*4-1:0]      sb_in2,
    output logic [NUM_SBOX*4-1:0]      sb_in3,
    output logic [NUM_SBOX*RAND_W-1:0] sb_r,
    input  logic [NUM_SBOX*4-1:0]      sb_out1,
    input  logic [NUM_SBOX*4-1:0]      sb_out2,
    input  logic [NUM_SBOX*4-1:0]      sb_out3
);
    localparam int BATCHES = 16 / NUM_SBOX;
    localparam int SW = NUM_SBOX * 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nxt;
    logic [63:0] sh1, sh2, sh3;
    logic [4:0] issue_cnt, capture_cnt;
    logic [LATENCY-1:0] pv;
    logic [3:0] pidx [LATENCY];
    logic issue, capture, last_cap;

    assign capture  = pv[LATENCY-1];
    assign last_cap = capture && capture_cnt == 5'(BATCHES - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = state == ISSUE && rand_valid;
        busy       = state != IDLE;
        rand_ready = busy && rand_valid;
        sb_r       = busy ? rand_in : '0;
        sb_in1     = issue ? sh1[int'(issue_cnt)*SW +: SW] : '0;
        sb_in2     = issue ? sh2[int'(issue_cnt)*SW +: SW] : '0;
        sb_in3     = issue ? sh3[int'(issue_cnt)*SW +: SW] : '0;
        if (state == IDLE && start) state_nxt = ISSUE;
        if (issue && issue_cnt == 5'(BATCHES - 1)) state_nxt = DRAIN;
        if (last_cap) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {sh1, sh2, sh3}    <= '0;
            {res1, res2, res3} <= '0;
            issue_cnt          <= '0;
            capture_cnt        <= '0;
            done               <= 1'b0;
            rand_starve        <= 1'b0;
            pv                 <= '0;
            for (int i = 0; i < LATENCY; i++) pidx[i] <= '0;
        end else begin
            done <= last_cap;
            if (state == IDLE && start) begin
                sh1         <= st1;
                sh2         <= st2;
                sh3         <= st3;
                issue_cnt   <= '0;
                capture_cnt <= '0;
                rand_starve <= 1'b0;
            end
            if (issue) issue_cnt <= issue_cnt + 5'd1;
            // the bank keeps consuming randomness while batches drain out
            if (state == DRAIN && !rand_valid) rand_starve <= 1'b1;
            pv[0]   <= issue;
            pidx[0] <= issue_cnt[3:0];
            for (int i = 1; i < LATENCY; i++) begin
                pv[i]   <= pv[i-1];
                pidx[i] <= pidx[i-1];
            end
            if (capture) begin
                res1[int'(pidx[LATENCY-1])*SW +: SW] <= sb_out1;
                res2[int'(pidx[LATENCY-1])*SW +: SW] <= sb_out2;
                res3[int'(pidx[LATENCY-1])*SW +: SW] <= sb_out3;
                capture_cnt <= capture_cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// tb_prince_sbox_layer_ctrl: randomized bench with a behavioural S-box bank and a
// nibble-level reference model of the inverse S-box layer and its timing.
module tb_prince_sbox_layer_ctrl;
    localparam int NS = 4;
    localparam int L  = 4;
    localparam int RW = 42;
    localparam int B  = 16 / NS;
    localparam int SW = NS * 4;

    logic clk = 1'b0;
    logic rst, start, busy, done, rand_valid, rand_ready, rand_starve;
    logic [63:0] st1, st2, st3, res1, res2, res3;
    logic [NS*RW-1:0] rand_in, sb_r;
    logic [SW-1:0] sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
    logic plain_bank;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    prince_sbox_layer_ctrl #(.NUM_SBOX(NS), .LATENCY(L), .RAND_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .st1(st1), .st2(st2), .st3(st3),
        .busy(busy), .done(done), .res1(res1), .res2(res2), .res3(res3),
        .rand_in(rand_in), .rand_valid(rand_valid), .rand_ready(rand_ready),
        .rand_starve(rand_starve), .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3),
        .sb_r(sb_r), .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
    );

    function automatic logic [3:0] inv4(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h1CE5046A98DF237B;
        return t[x*4 +: 4];
    endfunction

    function automatic logic [63:0] inv_layer(input logic [63:0] p);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) r[k*4 +: 4] = inv4(p[k*4 +: 4]);
        return r;
    endfunction

    function automatic logic [NS*RW-1:0] rnd_bits();
        logic [NS*RW-1:0] x;
        for (int i = 0; i < NS*RW; i++) x[i] = 1'($urandom_range(0, 1));
        return x;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // S-box bank: fixed LATENCY pipe, either unmasked in share 1 or a fresh-mask masked model
    logic [SW-1:0] q1 [L], q2 [L], q3 [L];
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            logic [3:0] a, b, c, m2, m3;
            a  = sb_in1[i*4 +: 4];
            b  = sb_in2[i*4 +: 4];
            c  = sb_in3[i*4 +: 4];
            m2 = sb_r[i*RW +: 4];
            m3 = sb_r[i*RW+4 +: 4];
            q1[0][i*4 +: 4] <= plain_bank ? inv4(a) : inv4(a ^ b ^ c) ^ m2 ^ m3;
            q2[0][i*4 +: 4] <= plain_bank ? b : m2;
            q3[0][i*4 +: 4] <= plain_bank ? c : m3;
        end
        for (int j = 1; j < L; j++) begin
            q1[j] <= q1[j-1];
            q2[j] <= q2[j-1];
            q3[j] <= q3[j-1];
        end
    end
    assign sb_out1 = q1[L-1];
    assign sb_out2 = q2[L-1];
    assign sb_out3 = q3[L-1];

    // off[c]=1 drops rand_valid in cycle c; called with the FSM idle, start goes out in cycle 0
    task automatic run_layer(input logic [63:0] plain, input bit masked, input logic [63:0] off,
                             input bit extra);
        logic [63:0] s2, s3, expv;
        int t, n, exp_done;
        bit starve_exp;
        s2 = masked ? rnd64() : 64'd0;
        s3 = masked ? rnd64() : 64'd0;
        expv = inv_layer(plain);
        t = 0;
        n = 0;
        while (n < B) begin
            t++;
            if (!off[t]) n++;
        end
        exp_done = t + L + 1;
        starve_exp = 1'b0;
        for (int c = t + 1; c <= t + L; c++) if (off[c]) starve_exp = 1'b1;
        plain_bank = !masked;
        start = 1'b1;
        st1 = plain ^ s2 ^ s3;
        st2 = s2;
        st3 = s3;
        rand_valid = 1'b1;
        rand_in = rnd_bits();
        for (int c = 1; c <= exp_done; c++) begin
            @(posedge clk);
            #1;
            start = extra && (c == 3 || c == 6);
            if (start) begin
                st1 = rnd64();
                st2 = rnd64();
                st3 = rnd64();
            end
            rand_valid = !off[c];
            rand_in = rnd_bits();
            #1;
            nvec++;
            if (done !== (c == exp_done)) begin
                nerr++;
                $display("FAIL done cycle %0d: got %b want %b", c, done, c == exp_done);
            end
            nvec++;
            if (busy !== (c < exp_done)) begin
                nerr++;
                $display("FAIL busy cycle %0d: got %b want %b", c, busy, c < exp_done);
            end
            if (c < exp_done) begin
                nvec++;
                if (rand_ready !== rand_valid || sb_r !== rand_in) begin
                    nerr++;
                    $display("FAIL rand_pass cycle %0d: ready %b valid %b sb_r_ok %b", c,
                             rand_ready, rand_valid, sb_r === rand_in);
                end
            end
            if (c == 1) begin
                nvec++;
                if (rand_starve !== 1'b0) begin
                    nerr++;
                    $display("FAIL starve_clear: got %b want 0", rand_starve);
                end
            end
        end
        nvec++;
        if ((res1 ^ res2 ^ res3) !== expv) begin
            nerr++;
            $display("FAIL result: got %h want %h (plain %h)", res1 ^ res2 ^ res3, expv, plain);
        end
        if (!masked) begin
            nvec++;
            if (res1 !== expv || res2 !== 64'd0 || res3 !== 64'd0) begin
                nerr++;
                $display("FAIL shares: got %h %h %h want %h 0 0", res1, res2, res3, expv);
            end
        end
        nvec++;
        if (rand_starve !== starve_exp) begin
            nerr++;
            $display("FAIL starve: got %b want %b", rand_starve, starve_exp);
        end
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        nvec++;
        if ({busy, done, rand_ready, rand_starve} !== 4'b0 || {res1, res2, res3} !== '0 ||
            {sb_in1, sb_in2, sb_in3} !== '0 || sb_r !== '0) begin
            nerr++;
            $display("FAIL %s: busy %b done %b ready %b starve %b res %h/%h/%h sb_in %h/%h/%h",
                     tag, busy, done, rand_ready, rand_starve, res1, res2, res3,
                     sb_in1, sb_in2, sb_in3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        st1 = '0;
        st2 = '0;
        st3 = '0;
        rand_valid = 1'b1;
        rand_in = rnd_bits();
        plain_bank = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_zero("idle");
    endtask

    task automatic test_known_vector();
        run_layer(64'h0123456789ABCDEF, 1'b0, 64'd0, 1'b0);
        nvec++;
        if (res1 !== 64'hB732FD89A6405EC1) begin
            nerr++;
            $display("FAIL known_vector: got %h want b732fd89a6405ec1", res1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 100; i++) run_layer(rnd64(), 1'b1, 64'd0, 1'b0);
    endtask

    task automatic test_issue_stall();
        run_layer(rnd64(), 1'b1, 64'h0C, 1'b0);
    endtask

    task automatic test_drain_starve();
        run_layer(rnd64(), 1'b1, 64'h40, 1'b0);
        @(posedge clk);
        #2;
        nvec++;
        if (rand_starve !== 1'b1) begin
            nerr++;
            $display("FAIL starve_sticky: got %b want 1", rand_starve);
        end
        run_layer(rnd64(), 1'b1, 64'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        st1 = rnd64();
        st2 = '0;
        st3 = '0;
        plain_bank = 1'b1;
        rand_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rst = (c == 4);
            #1;
        end
        check_zero("reset_mid");
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #2;
            nvec++;
            if (done !== 1'b0 || res1 !== 64'd0) begin
                nerr++;
                $display("FAIL stale_capture: done %b res1 %h want 0 0", done, res1);
            end
        end
        run_layer(rnd64(), 1'b0, 64'd0, 1'b0);
    endtask

    task automatic test_busy_start();
        run_layer(rnd64(), 1'b1, 64'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_layer(rnd64(), 1'b1, 64'd0, 1'b0);
        run_layer(rnd64(), 1'b1, 64'h20, 1'b0);
        run_layer(rnd64(), 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_known_vector();
        @(posedge clk);
        #2;
        test_issue_stall();
        test_drain_starve();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
